// File: rtl/onehot_sequence_monitor.sv
// Checks that the coder's one-hot output walks 0001->0010->0100->1000 with ov on each wrap.
// Counts completed frames and errors, and reports a lock status.
module onehot_sequence_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       code,
    input  logic             ov,
    output logic             locked,
    output logic [1:0]       idx,
    output logic             frame_ok,
    output logic             code_err,
    output logic             seq_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;
    localparam logic [3:0] FRAME_START = 4'b0001;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [3:0] expected;
    logic [3:0] expected_nxt;
    logic       one_hot;
    logic [1:0] code_idx;
    logic       hit_code_err;
    logic       hit_seq_err;
    logic       hit_frame;

    // The state register is the lock status; exposing it directly keeps it observable.
    assign locked  = (state == LOCKED);
    assign one_hot = (code != 4'b0000) && ((code & (code - 4'd1)) == 4'b0000);

    always_comb begin
        code_idx = 2'd0;
        case (code)
            4'b0010: code_idx = 2'd1;
            4'b0100: code_idx = 2'd2;
            4'b1000: code_idx = 2'd3;
            default: code_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        hit_code_err = 1'b0;
        hit_seq_err  = 1'b0;
        hit_frame    = 1'b0;
        if (!one_hot) begin
            hit_code_err = 1'b1;
            state_nxt    = UNLOCKED;
            expected_nxt = FRAME_START;
        end else if (state == UNLOCKED) begin
            // ov is deliberately ignored on the lock cycle.
            if (code == FRAME_START) begin
                state_nxt    = LOCKED;
                expected_nxt = {FRAME_START[2:0], FRAME_START[3]};
            end
        end else if ((code != expected) || ((code == FRAME_START) != ov)) begin
            hit_seq_err  = 1'b1;
            state_nxt    = UNLOCKED;
            expected_nxt = FRAME_START;
        end else begin
            expected_nxt = {expected[2:0], expected[3]};
            hit_frame    = (code == FRAME_START);
        end
    end

    // en qualifies sampling: with en low every register holds and the pulses drop to 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= UNLOCKED;
            expected  <= FRAME_START;
            idx       <= 2'd0;
            frame_ok  <= 1'b0;
            code_err  <= 1'b0;
            seq_err   <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            frame_ok <= en & hit_frame;
            code_err <= en & hit_code_err;
            seq_err  <= en & hit_seq_err;
            if (en) begin
                state    <= state_nxt;
                expected <= expected_nxt;
                if (one_hot) begin
                    idx <= code_idx;
                end
                if (hit_frame) begin
                    frame_cnt <= frame_cnt + CNT_ONE;
                end
                if ((hit_code_err || hit_seq_err) && (err_cnt != {CNT_W{1'b1}})) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_onehot_sequence_monitor.sv
// Bench for onehot_sequence_monitor: a CNT_W=8 and a CNT_W=2 instance share one stimulus stream.
// Outputs are compared to a frame-position model, to a hand-written vector table and to fixed checkpoints.
module tb_onehot_sequence_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] code;
    logic       ov;

    logic       locked8, frame_ok8, code_err8, seq_err8;
    logic [1:0] idx8;
    logic [7:0] frame_cnt8, err_cnt8;
    logic       locked2, frame_ok2, code_err2, seq_err2;
    logic [1:0] idx2;
    logic [1:0] frame_cnt2, err_cnt2;

    onehot_sequence_monitor #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .code(code), .ov(ov),
        .locked(locked8), .idx(idx8), .frame_ok(frame_ok8), .code_err(code_err8),
        .seq_err(seq_err8), .frame_cnt(frame_cnt8), .err_cnt(err_cnt8)
    );

    onehot_sequence_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .code(code), .ov(ov),
        .locked(locked2), .idx(idx2), .frame_ok(frame_ok2), .code_err(code_err2),
        .seq_err(seq_err2), .frame_cnt(frame_cnt2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: lock flag plus the position (0..3) of the next frame slot, with unbounded totals.
    bit m_locked;
    int m_pos;
    int m_idx;
    int m_frames;
    int m_errs;
    bit m_fo, m_ce, m_se;

    typedef struct {
        logic       en;
        logic [3:0] code;
        logic       ov;
        logic       locked;
        int         idx;
        logic       fo;
        logic       ce;
        logic       se;
        int         fc;
        int         ec;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_step();
        int ones;
        int pos;
        m_fo = 1'b0;
        m_ce = 1'b0;
        m_se = 1'b0;
        if (!reset) begin
            m_locked = 1'b0;
            m_pos    = 0;
            m_idx    = 0;
            m_frames = 0;
            m_errs   = 0;
        end else if (en) begin
            ones = 0;
            pos  = 0;
            for (int b = 0; b < 4; b++) begin
                if (code[b]) begin
                    ones++;
                    pos = b;
                end
            end
            if (ones != 1) begin
                m_ce = 1'b1;
                m_errs++;
                m_locked = 1'b0;
                m_pos = 0;
            end else begin
                m_idx = pos;
                if (!m_locked) begin
                    if (pos == 0) begin
                        m_locked = 1'b1;
                        m_pos = 1;
                    end
                end else if (pos != m_pos || ((pos == 0) != ov)) begin
                    m_se = 1'b1;
                    m_errs++;
                    m_locked = 1'b0;
                    m_pos = 0;
                end else begin
                    m_pos = (m_pos + 1) % 4;
                    if (pos == 0) begin
                        m_fo = 1'b1;
                        m_frames++;
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        check("locked8", locked8, m_locked);
        check("idx8", idx8, m_idx);
        check("frame_ok8", frame_ok8, m_fo);
        check("code_err8", code_err8, m_ce);
        check("seq_err8", seq_err8, m_se);
        check("frame_cnt8", frame_cnt8, m_frames % 256);
        check("err_cnt8", err_cnt8, sat(m_errs, 255));
        check("locked2", locked2, m_locked);
        check("idx2", idx2, m_idx);
        check("frame_ok2", frame_ok2, m_fo);
        check("code_err2", code_err2, m_ce);
        check("seq_err2", seq_err2, m_se);
        check("frame_cnt2", frame_cnt2, m_frames % 4);
        check("err_cnt2", err_cnt2, sat(m_errs, 3));
    endtask

    // Inputs change only around the falling edge; outputs are read on the falling edge.
    task automatic step(input logic r, input logic e, input logic [3:0] c, input logic o);
        reset = r;
        en    = e;
        code  = c;
        ov    = o;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic add_vec(input logic e, input logic [3:0] c, input logic o, input logic l,
                           input int i, input logic fo, input logic ce, input logic se,
                           input int fc, input int ec);
        vec_t v;
        v.en = e; v.code = c; v.ov = o; v.locked = l; v.idx = i;
        v.fo = fo; v.ce = ce; v.se = se; v.fc = fc; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic good_frame_tail();
        step(1'b1, 1'b1, 4'b0010, 1'b0);
        step(1'b1, 1'b1, 4'b0100, 1'b0);
        step(1'b1, 1'b1, 4'b1000, 1'b0);
        step(1'b1, 1'b1, 4'b0001, 1'b1);
    endtask

    initial begin
        int p;
        logic e;
        logic [3:0] c;
        logic o;

        //             en  code     ov  lock idx fo ce se fc ec
        add_vec(1'b1, 4'b0001, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        add_vec(1'b1, 4'b0010, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0);
        add_vec(1'b1, 4'b0100, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 0, 0);
        add_vec(1'b1, 4'b1000, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 0, 0);
        add_vec(1'b1, 4'b0001, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1, 0);
        add_vec(1'b1, 4'b0010, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 0);
        add_vec(1'b1, 4'b0110, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1, 1);
        add_vec(1'b1, 4'b0100, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1, 1);
        add_vec(1'b1, 4'b0001, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1, 1);
        add_vec(1'b1, 4'b0010, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 1);
        add_vec(1'b1, 4'b1000, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1, 2);
        add_vec(1'b1, 4'b0001, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1, 2);
        add_vec(1'b1, 4'b0010, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 2);
        add_vec(1'b1, 4'b0100, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1, 3);
        add_vec(1'b1, 4'b0001, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1, 3);
        add_vec(1'b1, 4'b0010, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 3);
        add_vec(1'b1, 4'b0100, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1, 3);
        add_vec(1'b1, 4'b1000, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1, 3);
        add_vec(1'b1, 4'b0001, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 4);
        add_vec(1'b1, 4'b0001, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1, 4);
        add_vec(1'b0, 4'b0000, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1, 4);
        add_vec(1'b1, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1, 5);

        reset = 1'b0;
        en    = 1'b0;
        code  = 4'b0000;
        ov    = 1'b0;

        // Reset state.
        step(1'b0, 1'b1, 4'b0001, 1'b1);
        step(1'b0, 1'b1, 4'b0001, 1'b1);
        check("rst_locked", locked8, 0);
        check("rst_frame_cnt", frame_cnt8, 0);
        check("rst_err_cnt", err_cnt8, 0);

        // Hand-computed vector table.
        foreach (vecs[k]) begin
            step(1'b1, vecs[k].en, vecs[k].code, vecs[k].ov);
            check($sformatf("vec%0d_locked", k), locked8, vecs[k].locked);
            check($sformatf("vec%0d_idx", k), idx8, vecs[k].idx);
            check($sformatf("vec%0d_frame_ok", k), frame_ok8, vecs[k].fo);
            check($sformatf("vec%0d_code_err", k), code_err8, vecs[k].ce);
            check($sformatf("vec%0d_seq_err", k), seq_err8, vecs[k].se);
            check($sformatf("vec%0d_frame_cnt", k), frame_cnt8, vecs[k].fc);
            check($sformatf("vec%0d_err_cnt", k), err_cnt8, vecs[k].ec);
        end

        // Free-running chain for 5 frames from a fresh reset.
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 4'b0001, 1'b1);
        check("chain_lock", locked8, 1);
        for (int f = 0; f < 4; f++) good_frame_tail();
        good_frame_tail();
        check("chain_frame_cnt8", frame_cnt8, 5);
        check("chain_frame_cnt2", frame_cnt2, 1);
        check("chain_err_cnt", err_cnt8, 0);

        // Freeze mid-frame with en low, then resume at the expected code.
        step(1'b1, 1'b1, 4'b0010, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            check("hold_locked", locked8, 1);
            check("hold_idx", idx8, 1);
            check("hold_frame_cnt", frame_cnt8, 5);
        end
        step(1'b1, 1'b1, 4'b0100, 1'b0);
        step(1'b1, 1'b1, 4'b1000, 1'b0);
        step(1'b1, 1'b1, 4'b0001, 1'b1);
        check("resume_frame_ok", frame_ok8, 1);
        check("resume_err_cnt", err_cnt8, 0);

        // Saturation and wrap on the narrow counter, then reset mid-frame.
        step(1'b0, 1'b1, 4'b0001, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 4'b0000, 1'b0);
        check("sat_err_cnt2", err_cnt2, 3);
        check("sat_err_cnt8", err_cnt8, 5);
        check("sat_code_err2", code_err2, 1);
        step(1'b1, 1'b1, 4'b0001, 1'b1);
        for (int f = 0; f < 4; f++) good_frame_tail();
        check("wrap_frame_cnt2_0", frame_cnt2, 0);
        good_frame_tail();
        check("wrap_frame_cnt2_1", frame_cnt2, 1);
        step(1'b1, 1'b1, 4'b0010, 1'b0);
        step(1'b0, 1'b1, 4'b0100, 1'b0);
        check("midrst_locked", locked2, 0);
        check("midrst_frame_cnt2", frame_cnt2, 0);
        check("midrst_err_cnt2", err_cnt2, 0);
        check("midrst_idx", idx8, 0);

        // Randomized chain with occasional corruption, stalls and resets.
        p = 0;
        for (int k = 0; k < 1500; k++) begin
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 14) == 0) begin
                c = 4'($urandom_range(0, 15));
                o = 1'($urandom_range(0, 1));
            end else begin
                c = 4'(1 << p);
                o = (p == 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                step(1'b0, e, c, o);
                p = 0;
            end else begin
                step(1'b1, e, c, o);
                if (e) p = (p + 1) % 4;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/onehot_sequence_monitor.md
Name: onehot_sequence_monitor

Overview:
- Downstream checker for the 2-bit counter and 4-to-2 coder stage.
- Samples the coder's 4-bit one-hot output and the counter's overflow strobe every enabled cycle.
- Verifies that codes arrive in the order 0001 -> 0010 -> 0100 -> 1000 -> 0001, with `ov` aligned to each wrap.
- Counts completed frames and errors, and drives a lock status for the system/debug bus.

Parameters:
- CNT_W, 8, width of `frame_cnt` and `err_cnt`.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  sample enable; when 0, the block holds all state.
- code  input  4  one-hot code from the coder stage.
- ov  input  1  counter overflow strobe; high in the cycle the counter wraps 3 -> 0.
- locked  output  1  high while the sequence is being tracked.
- idx  output  2  registered binary index of the last valid one-hot code.
- frame_ok  output  1  one-cycle pulse per completed, correctly aligned frame.
- code_err  output  1  one-cycle pulse when the sampled code is not one-hot (0 or 2+ bits set).
- seq_err  output  1  one-cycle pulse when the code is one-hot but out of order, or `ov` is misaligned.
- frame_cnt  output  CNT_W  completed frame count; wraps.
- err_cnt  output  CNT_W  total error count; saturates at all-ones.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=UNLOCKED, expected=4'b0001.
  - locked=0, idx=0, all pulses=0, frame_cnt=0, err_cnt=0.
  - Reset mid-frame discards all progress; no pulse in the reset cycle.
- All outputs are registered. Response appears one cycle after the sampling edge (latency 1).
- en==0: no sampling, state/expected/counters held, pulses forced 0.
- One-hot validity: code has exactly one bit set. `idx` updates only on a valid code with en=1.
- State UNLOCKED:
  - en & code==0001 -> LOCKED, expected<=0010, locked<=1. `ov` is ignored on the lock cycle.
  - en & non-one-hot code -> code_err pulse, err_cnt+1; stay UNLOCKED.
  - en & other one-hot code -> no error; stay UNLOCKED (waiting for frame start).
- State LOCKED, per en cycle, checks in priority order:
  1. Code not one-hot -> code_err pulse, err_cnt+1, -> UNLOCKED, expected<=0001.
  2. code!=expected -> seq_err pulse, err_cnt+1, -> UNLOCKED.
  3. code==expected==0001 but ov==0 -> seq_err pulse, err_cnt+1, -> UNLOCKED.
  4. code==expected!=0001 but ov==1 -> seq_err pulse, err_cnt+1, -> UNLOCKED.
  5. Otherwise match: expected<=rotate-left(expected), i.e. 1000 -> 0001.
     - If code==0001 (with ov==1): frame_ok pulse, frame_cnt+1 (modulo 2^CNT_W).
- Only one of code_err/seq_err fires per cycle; code_err has priority.
- A cycle that raises an error never raises frame_ok.
- err_cnt saturation: at all-ones, further errors still pulse but the count holds.
- frame_cnt wraps from all-ones to 0 without any flag.
- Error recovery: after an error in LOCKED, a code==0001 in the same cycle does NOT relock; relock requires a later 0001 sample.

Test Plan:
1. Reset low 2 cycles, then en=1 with the counter+coder chain free-running (0001 + ov, 0010, 0100, 1000, ...) for 5 frames -> locked=1 one cycle after the first 0001; frame_ok pulses at the start of frames 2-5; frame_cnt=4; err_cnt=0.
2. While locked, inject code=0110 for one cycle -> code_err pulse next cycle, err_cnt=1, locked=0; relock on the next 0001.
3. While locked, after 0010 drive 1000 -> seq_err pulse, err_cnt=1, locked=0; frame_cnt unchanged.
4. Locked, drive 0001 with ov=0 -> seq_err. Separately, drive 0100 with ov=1 -> seq_err. Both leave locked=0.
5. Hold en=0 for 6 cycles mid-frame with code toggling randomly -> all outputs and counters frozen; resuming at the expected code continues without error.
6. CNT_W=2: force 5 errors -> err_cnt sticks at 3. Run 5 good frames -> frame_cnt wraps to 0 then 1. Then assert reset mid-frame -> everything 0 next cycle.
